// File: rtl/shift_register_universal_pkg.sv
// Shared types for the universal shift register: operating modes and word-buffer states.
package shift_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      SHL  = 2'd1,
      SHR  = 2'd2,
      LOAD = 2'd3
   } mode_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_e;

endpackage

// File: rtl/shift_register_universal_if.sv
// Word handshake between the shift register's snapshot buffer and the word datapath.
// A word transfers on a rising edge where word_valid_o and word_ready_i are both high;
// while word_valid_o is high and word_ready_i is low, word_o is held stable.
interface shift_register_universal_if #(parameter int WIDTH = 16);
   logic [WIDTH-1:0] word_o;
   logic             word_valid_o;
   logic             word_ready_i;

   modport master (output word_o, output word_valid_o, input word_ready_i);
   modport slave  (input word_o, input word_valid_o, output word_ready_i);
endinterface

// File: rtl/shift_register_universal_word_buffer.sv
// Snapshot buffer for completed words: EMPTY/FULL FSM, valid/ready side and sticky overrun flag.
module shift_word_buffer
   import shift_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              complete,
   input  logic [WIDTH-1:0]                  word,
   shift_register_universal_if.master        bus,
   output logic                              overrun,
   output buf_state_e                        state
);

   buf_state_e       state_q, state_d;
   logic [WIDTH-1:0] word_q;
   logic             ovr_q;
   logic             load;
   logic             set_ovr;

   // A completion while FULL and ready is a simultaneous hand-off and refill.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      set_ovr = 1'b0;
      case (state_q)
         EMPTY: begin
            if (complete) begin
               load    = 1'b1;
               state_d = FULL;
            end
         end
         FULL: begin
            if (complete) begin
               if (bus.word_ready_i) load = 1'b1;
               else                  set_ovr = 1'b1;
            end else if (bus.word_ready_i) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         word_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load)    word_q <= word;
         if (set_ovr) ovr_q  <= 1'b1;
      end
   end

   assign bus.word_o       = word_q;
   assign bus.word_valid_o = (state_q == FULL);
   assign overrun          = ovr_q;
   assign state            = state_q;

endmodule

// File: rtl/shift_register_universal.sv
// Universal WIDTH-bit shift register with bit counter; completed words go to a snapshot buffer.
module shift_register_universal
   import shift_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en_i,
   input  mode_e                       mode_i,
   input  logic                        ser_i,
   input  logic [WIDTH-1:0]            par_i,
   output logic                        ser_o,
   output logic [WIDTH-1:0]            out_o,
   output logic [CNT_W-1:0]            count_o,
   shift_register_universal_if.master  word_bus,
   output logic                        overrun_o,
   output buf_state_e                  buf_state
);

   logic [WIDTH-1:0] reg_q, reg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             shift;
   logic             complete;

   always_comb begin
      reg_d    = reg_q;
      cnt_d    = cnt_q;
      shift    = 1'b0;
      complete = 1'b0;
      if (en_i) begin
         case (mode_i)
            SHL: begin
               reg_d = {reg_q[WIDTH-2:0], ser_i};
               shift = 1'b1;
            end
            SHR: begin
               reg_d = {ser_i, reg_q[WIDTH-1:1]};
               shift = 1'b1;
            end
            LOAD: begin
               reg_d = par_i;
               cnt_d = '0;
            end
            default: ;
         endcase
      end
      // Either direction counts; the shift taken at WIDTH-1 closes the word.
      complete = shift && (cnt_q == CNT_W'(WIDTH - 1));
      if (shift) cnt_d = complete ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_q <= '0;
         cnt_q <= '0;
      end else begin
         reg_q <= reg_d;
         cnt_q <= cnt_d;
      end
   end

   assign ser_o   = (mode_i == SHR) ? reg_q[0] : reg_q[WIDTH-1];
   assign out_o   = reg_q;
   assign count_o = cnt_q;

   shift_word_buffer #(.WIDTH(WIDTH)) u_word_buffer (
      .clk      (clk),
      .reset    (reset),
      .complete (complete),
      .word     (reg_d),
      .bus      (word_bus),
      .overrun  (overrun_o),
      .state    (buf_state)
   );

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal: directed scenarios plus a random run against a reference model.
module tb_shift_register_universal;
   import shift_pkg::*;

   localparam int W  = 16;
   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic          en_i;
   mode_e         mode_i;
   logic          ser_i;
   logic [W-1:0]  par_i;
   logic          ser_o;
   logic [W-1:0]  out_o;
   logic [CW-1:0] count_o;
   logic          overrun_o;
   buf_state_e    buf_state;

   shift_register_universal_if #(.WIDTH(W)) bus ();

   shift_register_universal #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .en_i      (en_i),
      .mode_i    (mode_i),
      .ser_i     (ser_i),
      .par_i     (par_i),
      .ser_o     (ser_o),
      .out_o     (out_o),
      .count_o   (count_o),
      .word_bus  (bus.master),
      .overrun_o (overrun_o),
      .buf_state (buf_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model and scoreboard
   logic [W-1:0]  mreg;
   logic [CW-1:0] mcnt;
   logic          mfull;
   logic          movr;
   logic [W-1:0]  exp_q[$];
   int            n_cmp;
   int            n_err;

   // driver: present inputs at the falling edge, score any handshake, clock, advance model
   task automatic step(input logic rst, input logic en, input mode_e mode, input logic ser,
                       input logic [W-1:0] par, input logic rdy);
      logic [W-1:0] exp;
      logic         comp;
      reset = rst;
      en_i = en;
      mode_i = mode;
      ser_i = ser;
      par_i = par;
      bus.word_ready_i = rdy;
      #1;
      if (!rst && bus.word_valid_o && rdy) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_underflow: word 0x%h offered, none expected", bus.word_o);
         end else begin
            exp = exp_q.pop_front();
            if (bus.word_o !== exp) begin
               n_err++;
               $display("FAIL sb_word: got 0x%h expected 0x%h", bus.word_o, exp);
            end
         end
      end
      @(posedge clk);
      comp = 1'b0;
      if (rst) begin
         mreg = '0;
         mcnt = '0;
         mfull = 1'b0;
         movr = 1'b0;
         exp_q.delete();
      end else begin
         if (en && mode == LOAD) begin
            mreg = par;
            mcnt = '0;
         end else if (en && (mode == SHL || mode == SHR)) begin
            mreg = (mode == SHL) ? {mreg[W-2:0], ser} : {ser, mreg[W-1:1]};
            comp = (mcnt == CW'(W - 1));
            mcnt = mcnt + CW'(1);
         end
         if (mfull) begin
            if (comp) begin
               if (rdy) exp_q.push_back(mreg);
               else     movr = 1'b1;
            end else if (rdy) begin
               mfull = 1'b0;
            end
         end else if (comp) begin
            exp_q.push_back(mreg);
            mfull = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, SHL, 1'b1, '1, 1'b0);
      step(1'b1, 1'b0, HOLD, 1'b0, '0, 1'b0);
      n_cmp++; if (out_o !== 16'h0000) begin n_err++; $display("FAIL rst_out: got 0x%h expected 0x0000", out_o); end
      n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", count_o); end
      n_cmp++; if (bus.word_o !== 16'h0000) begin n_err++; $display("FAIL rst_word: got 0x%h expected 0x0000", bus.word_o); end
      n_cmp++; if (bus.word_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", bus.word_valid_o); end
      n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b expected 0", overrun_o); end
      n_cmp++; if (buf_state !== EMPTY) begin n_err++; $display("FAIL rst_state: got %0d expected EMPTY", buf_state); end
   endtask

   task automatic test_shl_word();
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, SHL, ((i % 4) != 1), '0, 1'b0);
         if (i == 14) begin
            n_cmp++; if (bus.word_valid_o !== 1'b0) begin n_err++; $display("FAIL shl_early_valid: got %b expected 0", bus.word_valid_o); end
            n_cmp++; if (count_o !== 4'd15) begin n_err++; $display("FAIL shl_count15: got %0d expected 15", count_o); end
         end
      end
      n_cmp++; if (out_o !== 16'hBBBB) begin n_err++; $display("FAIL shl_out: got 0x%h expected 0xbbbb", out_o); end
      n_cmp++; if (bus.word_valid_o !== 1'b1) begin n_err++; $display("FAIL shl_valid: got %b expected 1", bus.word_valid_o); end
      n_cmp++; if (bus.word_o !== 16'hBBBB) begin n_err++; $display("FAIL shl_word: got 0x%h expected 0xbbbb", bus.word_o); end
      n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL shl_count: got %0d expected 0", count_o); end
   endtask

   task automatic test_load_shr();
      step(1'b0, 1'b1, HOLD, 1'b0, '0, 1'b1);
      step(1'b0, 1'b1, LOAD, 1'b0, 16'h8001, 1'b0);
      en_i = 1'b1; mode_i = SHR; ser_i = 1'b0;
      #1;
      n_cmp++; if (ser_o !== 1'b1) begin n_err++; $display("FAIL shr_ser_o: got %b expected 1", ser_o); end
      step(1'b0, 1'b1, SHR, 1'b0, '0, 1'b0);
      n_cmp++; if (out_o !== 16'h4000) begin n_err++; $display("FAIL shr_out: got 0x%h expected 0x4000", out_o); end
      n_cmp++; if (count_o !== 4'd1) begin n_err++; $display("FAIL shr_count: got %0d expected 1", count_o); end
      n_cmp++; if (bus.word_valid_o !== 1'b0) begin n_err++; $display("FAIL shr_valid: got %b expected 0", bus.word_valid_o); end
      step(1'b0, 1'b1, LOAD, 1'b0, 16'h0001, 1'b0);
      n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL load_count: got %0d expected 0", count_o); end
      en_i = 1'b0; mode_i = HOLD;
      #1;
      n_cmp++; if (ser_o !== 1'b0) begin n_err++; $display("FAIL ser_o_hold: got %b expected 0", ser_o); end
      mode_i = SHR;
      #1;
      n_cmp++; if (ser_o !== 1'b1) begin n_err++; $display("FAIL ser_o_shr: got %b expected 1", ser_o); end
      mode_i = SHL;
      #1;
      n_cmp++; if (ser_o !== 1'b0) begin n_err++; $display("FAIL ser_o_shl: got %b expected 0", ser_o); end
   endtask

   task automatic test_overrun();
      logic [W-1:0] w1;
      logic         b;
      w1 = '0;
      step(1'b1, 1'b0, HOLD, 1'b0, '0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         b = 1'($urandom_range(0, 1));
         if (i < 16) w1 = {w1[W-2:0], b};
         step(1'b0, 1'b1, SHL, b, '0, 1'b0);
      end
      n_cmp++; if (overrun_o !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b expected 1", overrun_o); end
      n_cmp++; if (bus.word_o !== w1) begin n_err++; $display("FAIL ovr_word: got 0x%h expected 0x%h", bus.word_o, w1); end
      n_cmp++; if (bus.word_valid_o !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b expected 1", bus.word_valid_o); end
      step(1'b0, 1'b0, HOLD, 1'b0, '0, 1'b1);
      n_cmp++; if (bus.word_valid_o !== 1'b0) begin n_err++; $display("FAIL ovr_drain: got %b expected 0", bus.word_valid_o); end
      n_cmp++; if (overrun_o !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b expected 1", overrun_o); end
   endtask

   task automatic test_ready_replace();
      logic [W-1:0] w2;
      logic         b;
      w2 = '0;
      step(1'b1, 1'b0, HOLD, 1'b0, '0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, SHL, 1'($urandom_range(0, 1)), '0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         b = 1'($urandom_range(0, 1));
         w2 = {w2[W-2:0], b};
         step(1'b0, 1'b1, SHL, b, '0, (i == 15));
      end
      n_cmp++; if (bus.word_o !== w2) begin n_err++; $display("FAIL repl_word: got 0x%h expected 0x%h", bus.word_o, w2); end
      n_cmp++; if (bus.word_valid_o !== 1'b1) begin n_err++; $display("FAIL repl_valid: got %b expected 1", bus.word_valid_o); end
      n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL repl_overrun: got %b expected 0", overrun_o); end
      step(1'b0, 1'b0, HOLD, 1'b0, '0, 1'b1);
   endtask

   task automatic test_reset_midword();
      step(1'b1, 1'b0, HOLD, 1'b0, '0, 1'b0);
      for (int i = 0; i < 25; i++) step(1'b0, 1'b1, SHL, 1'($urandom_range(0, 1)), '0, 1'b0);
      n_cmp++; if (count_o !== 4'd9) begin n_err++; $display("FAIL mid_count: got %0d expected 9", count_o); end
      n_cmp++; if (bus.word_valid_o !== 1'b1) begin n_err++; $display("FAIL mid_valid: got %b expected 1", bus.word_valid_o); end
      step(1'b1, 1'b1, SHL, 1'b1, '1, 1'b1);
      n_cmp++; if (out_o !== 16'h0000) begin n_err++; $display("FAIL mid_rst_out: got 0x%h expected 0x0000", out_o); end
      n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d expected 0", count_o); end
      n_cmp++; if (bus.word_o !== 16'h0000) begin n_err++; $display("FAIL mid_rst_word: got 0x%h expected 0x0000", bus.word_o); end
      n_cmp++; if (bus.word_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b expected 0", bus.word_valid_o); end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, SHL, 1'($urandom_range(0, 1)), '0, 1'b0);
         if (i == 14) begin
            n_cmp++; if (bus.word_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_early_valid: got %b expected 0", bus.word_valid_o); end
         end
      end
      n_cmp++; if (bus.word_valid_o !== 1'b1) begin n_err++; $display("FAIL mid_word_valid: got %b expected 1", bus.word_valid_o); end
      step(1'b0, 1'b0, HOLD, 1'b0, '0, 1'b1);
      n_cmp++; if (bus.word_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_one_word: got %b expected 0", bus.word_valid_o); end
      n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL mid_overrun: got %b expected 0", overrun_o); end
   endtask

   task automatic test_enable_low();
      logic [W-1:0]  exp_out;
      logic [CW-1:0] exp_cnt;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, SHL, 1'($urandom_range(0, 1)), '0, 1'b0);
      exp_out = mreg;
      exp_cnt = mcnt;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, SHL, 1'($urandom_range(0, 1)), '0, 1'b0);
      n_cmp++; if (out_o !== exp_out) begin n_err++; $display("FAIL en_out: got 0x%h expected 0x%h", out_o, exp_out); end
      n_cmp++; if (count_o !== exp_cnt) begin n_err++; $display("FAIL en_count: got %0d expected %0d", count_o, exp_cnt); end
   endtask

   task automatic test_back_to_back();
      step(1'b1, 1'b0, HOLD, 1'b0, '0, 1'b1);
      for (int i = 0; i < 64; i++)
         step(1'b0, 1'b1, ($urandom_range(0, 1) != 0) ? SHL : SHR, 1'($urandom_range(0, 1)), '0, 1'b1);
      n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b expected 0", overrun_o); end
      n_cmp++; if (bus.word_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b expected 1", bus.word_valid_o); end
      n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL b2b_count: got %0d expected 0", count_o); end
      step(1'b0, 1'b0, HOLD, 1'b0, '0, 1'b1);
   endtask

   task automatic test_random();
      mode_e m;
      int    r;
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 9));
         m = (r == 0) ? HOLD : (r == 1) ? LOAD : (r < 6) ? SHL : SHR;
         step(1'b0, ($urandom_range(0, 7) != 0), m, 1'($urandom_range(0, 1)),
              W'($urandom_range(0, 65535)), ($urandom_range(0, 3) == 0));
         n_cmp++; if (out_o !== mreg) begin n_err++; $display("FAIL rnd_out[%0d]: got 0x%h expected 0x%h", i, out_o, mreg); end
         n_cmp++; if (count_o !== mcnt) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count_o, mcnt); end
         n_cmp++; if (bus.word_valid_o !== mfull) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, bus.word_valid_o, mfull); end
         n_cmp++; if (overrun_o !== movr) begin n_err++; $display("FAIL rnd_overrun[%0d]: got %b expected %b", i, overrun_o, movr); end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      mreg = '0;
      mcnt = '0;
      mfull = 1'b0;
      movr = 1'b0;
      reset = 1'b1;
      en_i = 1'b0;
      mode_i = HOLD;
      ser_i = 1'b0;
      par_i = '0;
      bus.word_ready_i = 1'b0;
      @(negedge clk);
      test_reset();
      test_shl_word();
      test_load_shr();
      test_overrun();
      test_ready_replace();
      test_reset_midword();
      test_enable_low();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
